// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame
// Description : RS485 receive path. Oversampled UART deserialiser
//               (start, 8 data LSB first, stop) that writes each good byte
//               into a frame buffer and closes the frame after a line-idle
//               gap, reporting length and status.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int OVS   = 4,    // clk cycles per bit time (even, >= 2)
    parameter int BYTES = 18,   // expected bytes per frame / buffer depth
    parameter int GAP   = 4     // idle bit times that terminate a frame
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic [4:0] frame_len,
    output logic       frame_ok,
    output logic       busy
);

    localparam int c_CW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int c_GW = $clog2(GAP * OVS + 1);

    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(OVS / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(OVS - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP * OVS - 1);
    // One extra bit so that a full buffer (idx == BYTES) is representable.
    localparam logic [5:0]      c_BYTES    = 6'(BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchroniser
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;

    // Registered state
    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shreg;
    logic [5:0]      r_idx;
    logic            r_err;
    logic            r_busy;
    logic [c_GW-1:0] r_gap;
    logic            r_wr_en;
    logic [4:0]      r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_frame_done;
    logic [4:0]      r_frame_len;
    logic            r_frame_ok;

    // Next-state values
    state_t          w_state_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      w_shreg_nxt;
    logic [5:0]      w_idx_nxt;
    logic            w_err_nxt;
    logic            w_busy_nxt;
    logic [c_GW-1:0] w_gap_nxt;
    logic            w_wr_en_nxt;
    logic [4:0]      w_wr_addr_nxt;
    logic [7:0]      w_wr_data_nxt;
    logic            w_frame_done_nxt;
    logic [4:0]      w_frame_len_nxt;
    logic            w_frame_ok_nxt;

    assign w_rx_s = r_sync2;

    // Two-stage synchroniser for the asynchronous line; idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Character FSM, byte write port and inter-frame gap timer (next state)
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bit_nxt        = r_bit;
        w_shreg_nxt      = r_shreg;
        w_idx_nxt        = r_idx;
        w_err_nxt        = r_err;
        w_busy_nxt       = r_busy;
        w_gap_nxt        = r_gap;
        w_wr_en_nxt      = 1'b0;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;
        w_frame_done_nxt = 1'b0;
        w_frame_len_nxt  = r_frame_len;
        w_frame_ok_nxt   = r_frame_ok;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end

            S_START: begin
                // Half a bit in: still low means a real start bit.
                if (r_cnt == c_CNT_HALF) begin
                    if (!w_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = 3'd0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shreg_nxt[r_bit] = w_rx_s;
                    w_bit_nxt          = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_STOP: begin
                // Return to IDLE right after the stop sample so a
                // back-to-back start edge is seen on the very next cycle.
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    if (w_rx_s && (r_idx < c_BYTES)) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_idx[4:0];
                        w_wr_data_nxt = r_shreg;
                        w_idx_nxt     = r_idx + 6'd1;
                    end else begin
                        // Framing error or buffer overflow: byte discarded.
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Gap timer: any low level restarts it; it only advances while a
        // frame is open and the receiver sits idle on a high line.
        if (!w_rx_s) begin
            w_gap_nxt = '0;
        end else if (r_busy && (r_state == S_IDLE)) begin
            if (r_gap == c_GAP_LAST) begin
                w_frame_done_nxt = 1'b1;
                w_frame_len_nxt  = r_idx[4:0];
                w_frame_ok_nxt   = (r_idx == c_BYTES) && !r_err;
                w_idx_nxt        = '0;
                w_err_nxt        = 1'b0;
                w_busy_nxt       = 1'b0;
                w_gap_nxt        = '0;
            end else begin
                w_gap_nxt = r_gap + 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_shreg      <= 8'd0;
            r_idx        <= 6'd0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_gap        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 5'd0;
            r_wr_data    <= 8'd0;
            r_frame_done <= 1'b0;
            r_frame_len  <= 5'd0;
            r_frame_ok   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit        <= w_bit_nxt;
            r_shreg      <= w_shreg_nxt;
            r_idx        <= w_idx_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_gap        <= w_gap_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_frame_len  <= w_frame_len_nxt;
            r_frame_ok   <= w_frame_ok_nxt;
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign frame_len  = r_frame_len;
    assign frame_ok   = r_frame_ok;
    assign busy       = r_busy;

endmodule
`default_nettype wire
